calc_req_arbiter: RTL and testbench

- Parametrised multi-port request front end for the calculator execution unit.
- Each requester port feeds its own FIFO, which holds the command, tag, operand register addresses and data.
- A round-robin arbiter issues one request per handshake to a single execution-unit issue interface.
- Per-port outstanding-tag tracking blocks issue of any tag that has not yet been completed.

---
 rtl/calc_req_arbiter_if.sv | 50 +++++
 rtl/calc_req_arbiter.sv | 179 +++++++++++++++++
 tb/tb_calc_req_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_req_arbiter_if.sv
// Bundles the request, issue and completion signals of calc_req_arbiter.
//   slave  : arbiter side (takes requests/completions, drives issue/status)
//   master : environment side (requesters + execution unit)
// Per-port vectors pack port p into slice [p*W +: W].
interface calc_req_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 2,
    parameter int PORT_W    = $clog2(NUM_PORTS)
);
    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [4*NUM_PORTS-1:0]      req_cmd;
    logic [TAG_W*NUM_PORTS-1:0]  req_tag;
    logic [4*NUM_PORTS-1:0]      req_d1;
    logic [4*NUM_PORTS-1:0]      req_d2;
    logic [4*NUM_PORTS-1:0]      req_r1;
    logic [DATA_W*NUM_PORTS-1:0] req_data;

    logic                        issue_valid;
    logic                        issue_ready;
    logic [PORT_W-1:0]           issue_port;
    logic [3:0]                  issue_cmd;
    logic [3:0]                  issue_d1;
    logic [3:0]                  issue_d2;
    logic [3:0]                  issue_r1;
    logic [TAG_W-1:0]            issue_tag;
    logic [DATA_W-1:0]           issue_data;

    logic                        cmp_valid;
    logic [PORT_W-1:0]           cmp_port;
    logic [TAG_W-1:0]            cmp_tag;

    logic                        err_cmp;
    logic                        idle;

    modport slave (
        input  req_valid, req_cmd, req_tag, req_d1, req_d2, req_r1, req_data,
        input  issue_ready, cmp_valid, cmp_port, cmp_tag,
        output req_ready, issue_valid, issue_port, issue_cmd, issue_d1, issue_d2,
        output issue_r1, issue_tag, issue_data, err_cmp, idle
    );

    modport master (
        output req_valid, req_cmd, req_tag, req_d1, req_d2, req_r1, req_data,
        output issue_ready, cmp_valid, cmp_port, cmp_tag,
        input  req_ready, issue_valid, issue_port, issue_cmd, issue_d1, issue_d2,
        input  issue_r1, issue_tag, issue_data, err_cmp, idle
    );
endinterface

// File: rtl/calc_req_arbiter.sv
// calc_req_arbiter: multi-port request front end for the calculator
// execution unit. Each port has a FIFO of {cmd, tag, d1, d2, r1, data};
// a round-robin arbiter loads one head entry per handshake into a single
// issue register. A per-port outstanding-tag bitmap blocks a head whose tag
// has not yet been completed.
// Ports:
//   c_clk  : clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : calc_req_arbiter_if.slave (requests, issue, completion, status)
module calc_req_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 2,
    parameter int PORT_W     = $clog2(NUM_PORTS)
) (
    input  logic              c_clk,
    input  logic              reset,
    calc_req_arbiter_if.slave bus
);
    localparam int NTAGS = 1 << TAG_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [3:0]        cmd;
        logic [TAG_W-1:0]  tag;
        logic [3:0]        d1;
        logic [3:0]        d2;
        logic [3:0]        r1;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t [NUM_PORTS-1:0] head_entry;
    logic   [NUM_PORTS-1:0] elig;
    logic   [NUM_PORTS-1:0] nonempty;
    logic   [NUM_PORTS-1:0] out_any;
    logic   [NUM_PORTS-1:0] cmp_bad;

    logic              load;
    logic              any_elig;
    logic [PORT_W-1:0] winner;
    logic [PORT_W:0]   scan;

    logic              rdy_en_q;
    logic [PORT_W-1:0] last_grant_q, last_grant_d;
    logic              err_q, err_d;
    logic              issue_valid_q, issue_valid_d;
    logic [PORT_W-1:0] issue_port_q, issue_port_d;
    entry_t            issue_entry_q, issue_entry_d;

    // ------------------------------------------------------------ per port
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        entry_t            mem_q [FIFO_DEPTH];
        entry_t            in_entry;
        logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
        logic [CNT_W-1:0]  count_q, count_d;
        logic [NTAGS-1:0]  out_q, out_d;
        logic              push, pop, cmp_sel;

        assign in_entry.cmd  = bus.req_cmd[gi*4 +: 4];
        assign in_entry.tag  = bus.req_tag[gi*TAG_W +: TAG_W];
        assign in_entry.d1   = bus.req_d1[gi*4 +: 4];
        assign in_entry.d2   = bus.req_d2[gi*4 +: 4];
        assign in_entry.r1   = bus.req_r1[gi*4 +: 4];
        assign in_entry.data = bus.req_data[gi*DATA_W +: DATA_W];

        // ready is held low until the first edge after reset release
        assign bus.req_ready[gi] = rdy_en_q & (count_q != CNT_W'(FIFO_DEPTH));

        // a no-op command completes its handshake but is never stored
        assign push    = bus.req_valid[gi] & bus.req_ready[gi] & (in_entry.cmd != 4'd0);
        assign pop     = load & (winner == PORT_W'(gi));
        assign cmp_sel = bus.cmp_valid & (bus.cmp_port == PORT_W'(gi));

        assign head_entry[gi] = mem_q[rd_ptr_q];
        assign nonempty[gi]   = (count_q != '0);
        assign elig[gi]       = nonempty[gi] & ~out_q[head_entry[gi].tag];
        assign out_any[gi]    = |out_q;
        assign cmp_bad[gi]    = cmp_sel & ~out_q[bus.cmp_tag];

        always_comb begin
            count_d = count_q;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            // clear first, then set: a same-tag clash cannot happen because
            // the popped head was only eligible with its bit already clear
            out_d = out_q;
            if (cmp_sel) out_d[bus.cmp_tag] = 1'b0;
            if (pop)     out_d[head_entry[gi].tag] = 1'b1;
        end

        always_ff @(posedge c_clk or negedge reset) begin
            if (!reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                out_q    <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_d;
                out_q   <= out_d;
            end
        end

        // storage carries no reset; validity is tracked by count_q
        always_ff @(posedge c_clk) begin
            if (push) mem_q[wr_ptr_q] <= in_entry;
        end
    end

    // ------------------------------------------------------------ arbiter
    // Scan last_grant+1 .. last_grant+NUM_PORTS with modulo wrap; the first
    // eligible port wins.
    always_comb begin
        any_elig = 1'b0;
        winner   = '0;
        scan     = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            scan = {1'b0, last_grant_q} + (PORT_W+1)'(i);
            if (scan >= (PORT_W+1)'(NUM_PORTS)) scan = scan - (PORT_W+1)'(NUM_PORTS);
            if (!any_elig && elig[scan[PORT_W-1:0]]) begin
                any_elig = 1'b1;
                winner   = scan[PORT_W-1:0];
            end
        end
    end

    assign load = (~issue_valid_q | bus.issue_ready) & any_elig;

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_port_d  = issue_port_q;
        issue_entry_d = issue_entry_q;
        last_grant_d  = last_grant_q;
        if (load) begin
            issue_valid_d = 1'b1;
            issue_port_d  = winner;
            issue_entry_d = head_entry[winner];
            last_grant_d  = winner;
        end else if (bus.issue_ready) begin
            issue_valid_d = 1'b0;
        end
        err_d = err_q | (|cmp_bad);
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            rdy_en_q      <= 1'b0;
            last_grant_q  <= PORT_W'(NUM_PORTS - 1);
            err_q         <= 1'b0;
            issue_valid_q <= 1'b0;
            issue_port_q  <= '0;
            issue_entry_q <= '0;
        end else begin
            rdy_en_q      <= 1'b1;
            last_grant_q  <= last_grant_d;
            err_q         <= err_d;
            issue_valid_q <= issue_valid_d;
            issue_port_q  <= issue_port_d;
            issue_entry_q <= issue_entry_d;
        end
    end

    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_port  = issue_port_q;
    assign bus.issue_cmd   = issue_entry_q.cmd;
    assign bus.issue_tag   = issue_entry_q.tag;
    assign bus.issue_d1    = issue_entry_q.d1;
    assign bus.issue_d2    = issue_entry_q.d2;
    assign bus.issue_r1    = issue_entry_q.r1;
    assign bus.issue_data  = issue_entry_q.data;
    assign bus.err_cmp     = err_q;
    assign bus.idle        = ~issue_valid_q & ~(|nonempty) & ~(|out_any);
endmodule

// File: tb/tb_calc_req_arbiter.sv
// Testbench for calc_req_arbiter (4 ports, depth 4, 32-bit data, 2-bit tags).
module tb_calc_req_arbiter;
    logic c_clk = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 c_clk = ~c_clk;

    calc_req_arbiter_if #(.NUM_PORTS(4), .DATA_W(32), .TAG_W(2)) bus ();

    calc_req_arbiter #(
        .NUM_PORTS(4), .FIFO_DEPTH(4), .DATA_W(32), .TAG_W(2)
    ) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] vmask;
        logic [3:0] cmd;
        logic [1:0] tag;
        logic       ir;
        logic       cv;
        logic [1:0] cp;
        logic [1:0] ct;
        logic       e_iv;
        logic [1:0] e_ip;
        logic [1:0] e_tag;
        logic [3:0] e_rdy;
        logic       e_idle;
        logic       e_err;
    } vec_t;

    vec_t vt [34];

    function automatic vec_t mk(logic [3:0] vmask, logic [3:0] cmd, logic [1:0] tag,
                                logic ir, logic cv, logic [1:0] cp, logic [1:0] ct,
                                logic e_iv, logic [1:0] e_ip, logic [1:0] e_tag,
                                logic [3:0] e_rdy, logic e_idle, logic e_err);
        vec_t v;
        v.vmask = vmask; v.cmd = cmd; v.tag = tag; v.ir = ir;
        v.cv = cv; v.cp = cp; v.ct = ct;
        v.e_iv = e_iv; v.e_ip = e_ip; v.e_tag = e_tag;
        v.e_rdy = e_rdy; v.e_idle = e_idle; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    function automatic logic [31:0] pdata(int p, logic [1:0] tag);
        return 32'hA000_0000 | (32'(p) << 8) | 32'(tag);
    endfunction

    // Drive the same cmd/tag on every port in mask; other fields follow the port.
    task automatic drive(input logic [3:0] mask, input logic [3:0] cmd, input logic [1:0] tag);
        bus.req_valid = mask;
        for (int p = 0; p < 4; p++) begin
            bus.req_cmd[p*4 +: 4]   = cmd;
            bus.req_tag[p*2 +: 2]   = tag;
            bus.req_d1[p*4 +: 4]    = 4'(p);
            bus.req_d2[p*4 +: 4]    = 4'(p + 1);
            bus.req_r1[p*4 +: 4]    = 4'(p + 2);
            bus.req_data[p*32 +: 32] = pdata(p, tag);
        end
    endtask

    task automatic idle_inputs();
        drive(4'b0000, 4'd0, 2'd0);
        bus.cmp_valid = 1'b0;
        bus.cmp_port  = '0;
        bus.cmp_tag   = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        // table: three scenarios back to back from a clean reset
        vt[0]  = mk(4'b1111, 4'd1, 2'd0, 1, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 0);
        vt[1]  = mk(4'b0000, 4'd0, 2'd0, 1, 0, 0, 0, 1, 0, 0, 4'b1111, 0, 0);
        vt[2]  = mk(4'b0000, 4'd0, 2'd0, 1, 0, 0, 0, 1, 1, 0, 4'b1111, 0, 0);
        vt[3]  = mk(4'b0000, 4'd0, 2'd0, 1, 0, 0, 0, 1, 2, 0, 4'b1111, 0, 0);
        vt[4]  = mk(4'b0000, 4'd0, 2'd0, 1, 0, 0, 0, 1, 3, 0, 4'b1111, 0, 0);
        vt[5]  = mk(4'b0000, 4'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 0);
        vt[6]  = mk(4'b0000, 4'd0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 4'b1111, 0, 0);
        vt[7]  = mk(4'b0000, 4'd0, 2'd0, 1, 1, 1, 0, 0, 0, 0, 4'b1111, 0, 0);
        vt[8]  = mk(4'b0000, 4'd0, 2'd0, 1, 1, 2, 0, 0, 0, 0, 4'b1111, 0, 0);
        vt[9]  = mk(4'b0000, 4'd0, 2'd0, 1, 1, 3, 0, 0, 0, 0, 4'b1111, 1, 0);
        vt[10] = mk(4'b1111, 4'd1, 2'd0, 1, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 0);
        vt[11] = mk(4'b0000, 4'd0, 2'd0, 1, 0, 0, 0, 1, 0, 0, 4'b1111, 0, 0);
        vt[12] = mk(4'b0000, 4'd0, 2'd0, 1, 0, 0, 0, 1, 1, 0, 4'b1111, 0, 0);
        vt[13] = mk(4'b0000, 4'd0, 2'd0, 1, 0, 0, 0, 1, 2, 0, 4'b1111, 0, 0);
        vt[14] = mk(4'b0000, 4'd0, 2'd0, 1, 0, 0, 0, 1, 3, 0, 4'b1111, 0, 0);
        vt[15] = mk(4'b0000, 4'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 0);
        vt[16] = mk(4'b0000, 4'd0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 4'b1111, 0, 0);
        vt[17] = mk(4'b0000, 4'd0, 2'd0, 1, 1, 1, 0, 0, 0, 0, 4'b1111, 0, 0);
        vt[18] = mk(4'b0000, 4'd0, 2'd0, 1, 1, 2, 0, 0, 0, 0, 4'b1111, 0, 0);
        vt[19] = mk(4'b0000, 4'd0, 2'd0, 1, 1, 3, 0, 0, 0, 0, 4'b1111, 1, 0);
        vt[20] = mk(4'b0010, 4'd2, 2'd1, 1, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 0);
        vt[21] = mk(4'b0010, 4'd2, 2'd1, 1, 0, 0, 0, 1, 1, 1, 4'b1111, 0, 0);
        vt[22] = mk(4'b0000, 4'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 0);
        vt[23] = mk(4'b0000, 4'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 0);
        vt[24] = mk(4'b0000, 4'd0, 2'd0, 1, 1, 1, 1, 0, 0, 0, 4'b1111, 0, 0);
        vt[25] = mk(4'b0000, 4'd0, 2'd0, 1, 0, 0, 0, 1, 1, 1, 4'b1111, 0, 0);
        vt[26] = mk(4'b0000, 4'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 0);
        vt[27] = mk(4'b0000, 4'd0, 2'd0, 1, 1, 1, 1, 0, 0, 0, 4'b1111, 1, 0);
        vt[28] = mk(4'b1000, 4'd0, 2'd3, 1, 0, 0, 0, 0, 0, 0, 4'b1111, 1, 0);
        vt[29] = mk(4'b0000, 4'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 4'b1111, 1, 0);
        vt[30] = mk(4'b0000, 4'd0, 2'd0, 1, 1, 3, 3, 0, 0, 0, 4'b1111, 1, 1);
        vt[31] = mk(4'b0001, 4'd1, 2'd2, 1, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 1);
        vt[32] = mk(4'b0000, 4'd0, 2'd0, 1, 0, 0, 0, 1, 0, 2, 4'b1111, 0, 1);
        vt[33] = mk(4'b0000, 4'd0, 2'd0, 1, 1, 0, 2, 0, 0, 0, 4'b1111, 1, 1);

        idle_inputs();
        bus.issue_ready = 1'b0;

        // ---- reset state
        #1;
        chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
        chk("rst_req_ready",   64'(bus.req_ready),   64'd0);
        chk("rst_idle",        64'(bus.idle),        64'd1);
        chk("rst_err_cmp",     64'(bus.err_cmp),     64'd0);
        chk("rst_issue_cmd",   64'(bus.issue_cmd),   64'd0);
        chk("rst_issue_data",  64'(bus.issue_data),  64'd0);
        step();
        reset = 1'b1;
        step();
        chk("rel_req_ready", 64'(bus.req_ready), 64'hF);

        // ---- single request on port 0, full field check and latency
        bus.req_valid = 4'b0001;
        bus.req_cmd[3:0]  = 4'd1;
        bus.req_tag[1:0]  = 2'd2;
        bus.req_d1[3:0]   = 4'd3;
        bus.req_d2[3:0]   = 4'd4;
        bus.req_r1[3:0]   = 4'd5;
        bus.req_data[31:0] = 32'h0000_0005;
        step();
        idle_inputs();
        chk("p0_accept_iv", 64'(bus.issue_valid), 64'd0);
        step();
        chk("p0_iv",   64'(bus.issue_valid), 64'd1);
        chk("p0_port", 64'(bus.issue_port),  64'd0);
        chk("p0_cmd",  64'(bus.issue_cmd),   64'd1);
        chk("p0_tag",  64'(bus.issue_tag),   64'd2);
        chk("p0_d1",   64'(bus.issue_d1),    64'd3);
        chk("p0_d2",   64'(bus.issue_d2),    64'd4);
        chk("p0_r1",   64'(bus.issue_r1),    64'd5);
        chk("p0_data", 64'(bus.issue_data),  64'h5);
        chk("p0_idle", 64'(bus.idle),        64'd0);

        // ---- table-driven: round robin, tag blocking, no-op, sticky error
        do_reset();
        for (int i = 0; i < 34; i++) begin
            drive(vt[i].vmask, vt[i].cmd, vt[i].tag);
            bus.issue_ready = vt[i].ir;
            bus.cmp_valid   = vt[i].cv;
            bus.cmp_port    = vt[i].cp;
            bus.cmp_tag     = vt[i].ct;
            step();
            chk($sformatf("v%0d_iv", i), 64'(bus.issue_valid), 64'(vt[i].e_iv));
            if (vt[i].e_iv) begin
                chk($sformatf("v%0d_port", i), 64'(bus.issue_port), 64'(vt[i].e_ip));
                chk($sformatf("v%0d_tag", i),  64'(bus.issue_tag),  64'(vt[i].e_tag));
            end
            chk($sformatf("v%0d_rdy", i),  64'(bus.req_ready), 64'(vt[i].e_rdy));
            chk($sformatf("v%0d_idle", i), 64'(bus.idle),      64'(vt[i].e_idle));
            chk($sformatf("v%0d_err", i),  64'(bus.err_cmp),   64'(vt[i].e_err));
        end
        idle_inputs();

        // ---- port 2 fills with issue stalled; issue register holds steady
        bus.issue_ready = 1'b0;
        begin
            logic [1:0] tags [5];
            tags[0] = 2'd0; tags[1] = 2'd1; tags[2] = 2'd2; tags[3] = 2'd3; tags[4] = 2'd0;
            for (int i = 0; i < 5; i++) begin
                drive(4'b0100, 4'd3, tags[i]);
                chk($sformatf("fill%0d_ready2", i), 64'(bus.req_ready[2]), 64'd1);
                step();
            end
        end
        idle_inputs();
        chk("full_ready", 64'(bus.req_ready), 64'b1011);
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("hold%0d_iv", c),   64'(bus.issue_valid), 64'd1);
            chk($sformatf("hold%0d_port", c), 64'(bus.issue_port),  64'd2);
            chk($sformatf("hold%0d_tag", c),  64'(bus.issue_tag),   64'd0);
            chk($sformatf("hold%0d_data", c), 64'(bus.issue_data),  64'(pdata(2, 2'd0)));
            step();
        end
        chk("still_full_ready2", 64'(bus.req_ready[2]), 64'd0);
        bus.issue_ready = 1'b1;
        for (int t = 1; t < 4; t++) begin
            step();
            chk($sformatf("drain_tag%0d_iv", t),   64'(bus.issue_valid), 64'd1);
            chk($sformatf("drain_tag%0d", t),      64'(bus.issue_tag),   64'(t));
            chk($sformatf("drain_tag%0d_data", t), 64'(bus.issue_data),  64'(pdata(2, 2'(t))));
        end
        step();
        chk("hol_blocked_iv", 64'(bus.issue_valid), 64'd0);
        chk("drain_ready2",   64'(bus.req_ready[2]), 64'd1);

        // ---- load other ports, then reset in the middle of a cycle
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(4'b1011, 4'd4, 2'(i));
            step();
        end
        idle_inputs();
        chk("busy_idle", 64'(bus.idle),      64'd0);
        chk("busy_err",  64'(bus.err_cmp),   64'd1);
        chk("busy_rdy0", 64'(bus.req_ready[0]), 64'd0);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_iv",   64'(bus.issue_valid), 64'd0);
        chk("midrst_rdy",  64'(bus.req_ready),   64'd0);
        chk("midrst_idle", 64'(bus.idle),        64'd1);
        chk("midrst_err",  64'(bus.err_cmp),     64'd0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("post_rdy",  64'(bus.req_ready), 64'hF);
        chk("post_idle", 64'(bus.idle),      64'd1);
        chk("post_err",  64'(bus.err_cmp),   64'd0);
        bus.issue_ready = 1'b1;
        drive(4'b1111, 4'd1, 2'd0);
        step();
        idle_inputs();
        step();
        chk("post_first_iv",   64'(bus.issue_valid), 64'd1);
        chk("post_first_port", 64'(bus.issue_port),  64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
